// File: rtl/up_down_counter_mod.sv
// up_down_counter_mod
//   Parametrised up/down event counter. It has a programmable modulus,
//   wrap or saturate at the limits, a clock enable and a synchronous
//   parallel load. It also produces a registered terminal-count pulse and
//   sticky overflow/underflow flags.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   MAX_VAL   highest count value; the count range is 0..MAX_VAL
//   SATURATE  0 = wrap at the limits, 1 = hold at the limits
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   en         count enable
//   up_down    direction: 1 = up, 0 = down
//   load       synchronous parallel load strobe (has priority over en)
//   load_val   value to load, clamped to MAX_VAL
//   clr_flags  synchronous clear of ovf/udf (a same-edge limit event wins)
//   count      current count, registered
//   tc         one-cycle pulse following each limit event
//   ovf        sticky overflow flag (up limit event)
//   udf        sticky underflow flag (down limit event)
module up_down_counter_mod #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             udf
);

    logic [WIDTH-1:0] count_nxt;
    logic             lim_up;
    logic             lim_dn;

    // The limit is detected on the current count before stepping. As a
    // result, no intermediate value ever needs more than WIDTH bits, and
    // MAX_VAL = 2**WIDTH-1 needs no special case.
    always_comb begin
        count_nxt = count;
        lim_up    = 1'b0;
        lim_dn    = 1'b0;
        if (load) begin
            count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (up_down) begin
                if (count == MAX_VAL) begin
                    lim_up    = 1'b1;
                    count_nxt = (SATURATE != 0) ? MAX_VAL : '0;
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    lim_dn    = 1'b1;
                    count_nxt = (SATURATE != 0) ? '0 : MAX_VAL;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            count <= count_nxt;
            // In saturate mode, tc re-pulses on every enabled edge at the limit.
            tc    <= lim_up | lim_dn;
            // A set on the same edge overrides a clear.
            ovf   <= lim_up | (ovf & ~clr_flags);
            udf   <= lim_dn | (udf & ~clr_flags);
        end
    end

endmodule

// File: doc/up_down_counter_mod.md
Name: up_down_counter_mod

Overview:
Parametrised successor to the team's fixed 4-bit up/down counter. It adds generic width, a programmable modulus, wrap or saturate mode, clock enable, synchronous parallel load, a registered terminal-count pulse and sticky overflow/underflow flags. It is used as a general event/position counter in timer, PWM and address-generation blocks.

Parameters:
WIDTH, 8, counter width in bits (>=2).
MAX_VAL, 2**WIDTH-1, highest count value; the count range is 0..MAX_VAL (must be < 2**WIDTH).
SATURATE, 0, 0 = wrap at the limits; 1 = hold at the limits.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
en  input  1  count enable; count advances only when en=1.
up_down  input  1  direction: 1 = up, 0 = down.
load  input  1  synchronous parallel load strobe.
load_val  input  WIDTH  value to load.
clr_flags  input  1  synchronous clear of ovf and udf.
count  output  WIDTH  current count, registered.
tc  output  1  terminal-count pulse, registered, one cycle wide.
ovf  output  1  sticky overflow flag.
udf  output  1  sticky underflow flag.

Behaviour:
- Reset (asynchronous, active-high): count=0, tc=0, ovf=0, udf=0 immediately, independent of clk. On the first edge after reset deasserts, the block operates normally.
- All other state updates occur on the rising edge of clk.
- Priority each edge: load > en > hold.
- Load (load=1):
  - count <= load_val, clamped to MAX_VAL if load_val > MAX_VAL.
  - tc <= 0; ovf and udf are not affected by the load itself.
  - en is ignored in a load cycle.
- Hold (en=0, load=0): count holds; tc <= 0.
- Up (en=1, up_down=1):
  - count < MAX_VAL: count+1.
  - count == MAX_VAL: limit event. SATURATE=0: count <= 0. SATURATE=1: count holds at MAX_VAL.
- Down (en=1, up_down=0):
  - count > 0: count-1.
  - count == 0: limit event. SATURATE=0: count <= MAX_VAL. SATURATE=1: count holds at 0.
- tc: is 1 in the cycle immediately following a limit event, otherwise 0.
  - In saturate mode, tc re-pulses on every enabled edge while the count is held at the limit.
- Flags:
  - An up limit event sets ovf; a down limit event sets udf.
  - Flags stay set until clr_flags=1.
  - If a limit event and clr_flags occur on the same edge, set wins (the flag stays 1).
- Direction may change on any edge; the new direction applies to that edge. No pipeline and no dead cycle.
- Latency: count reflects an input on the first rising edge after it is sampled.
- Arithmetic is unsigned at WIDTH bits. No intermediate value may exceed WIDTH bits; the increment is compared before it is applied, so MAX_VAL = 2**WIDTH-1 wraps cleanly.
- Reset asserted mid-count overrides everything, including load and clr_flags on that cycle.

Test Plan:
1. WIDTH=4, MAX_VAL=15, SATURATE=0; reset 10ns, then up_down=1, en=1 for 17 clocks -> count 0..15, then 0 on the 16th edge; tc=1 for exactly one cycle after the 15->0 edge; ovf=1 from then on; udf=0.
2. Same configuration, load=1 with load_val=2, then up_down=0 for 4 clocks -> count 2,1,0,15,14; tc pulses once after the 0->15 edge; udf=1.
3. WIDTH=4, MAX_VAL=9, SATURATE=0, up -> count sequence 7,8,9,0,1. Then load_val=12 -> count=9 (clamped).
4. WIDTH=4, MAX_VAL=9, SATURATE=1, up for 12 clocks from 0 -> count sticks at 9; tc=1 on every enabled edge at the limit; ovf=1. Then down 3 clocks -> 8,7,6 and tc=0.
5. Simultaneous events and enable gating:
   - Limit event with clr_flags=1 on the same edge -> ovf stays 1.
   - clr_flags alone -> ovf=0 and udf=0 next edge.
   - en=0 for 5 clocks -> count holds and tc=0.
6. Assert reset asynchronously mid-cycle while count=6 with load=1 -> count, tc, ovf and udf go to 0 before the next edge. After release, counting resumes from 0.
